// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master transfer engine: transfer FSM state
// type, default data and divider widths, and a sizing helper for the SCLK
// edge counter.
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W    = 8;
    localparam int SPI_CLK_DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_ctrl_state_t;

    // Width of a counter that must hold 0..2*data_w SCLK edges.
    function automatic int spi_edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_transfer_ctrl_if.sv
// -----------------------------------------------------------------------------
// spi_transfer_ctrl_if
// Bundles the register-file side (start/config/status/data) and the SPI pin
// side of the transfer engine.
//   master : register file + pins environment (drives start, tx_data, clk_div,
//            cpol, cpha, miso; observes busy, done, rx_data, sclk, mosi, ss_n)
//   slave  : spi_transfer_ctrl
// -----------------------------------------------------------------------------
interface spi_transfer_ctrl_if
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) ();

    logic                     start;
    logic [DATA_W-1:0]        tx_data;
    logic [SPI_CLK_DIV_W-1:0] clk_div;
    logic                     cpol;
    logic                     cpha;
    logic                     busy;
    logic                     done;
    logic [DATA_W-1:0]        rx_data;
    logic                     sclk;
    logic                     mosi;
    logic                     miso;
    logic                     ss_n;

    modport master (
        output start, tx_data, clk_div, cpol, cpha, miso,
        input  busy, done, rx_data, sclk, mosi, ss_n
    );

    modport slave (
        input  start, tx_data, clk_div, cpol, cpha, miso,
        output busy, done, rx_data, sclk, mosi, ss_n
    );

endinterface

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period timer for the transfer engine. A down-counter is reloaded with
// the divider captured at load time and emits a one-cycle tick every
// (div+1) enabled cycles. While i_shift is high each tick is an SCLK edge and
// o_lead tells whether it is the leading (odd) or trailing (even) edge.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : capture i_div and restart the timer (transfer accepted)
//   i_div        : clk_div value to capture
//   i_en         : timer runs (transfer active)
//   i_shift      : ticks are SCLK edges (parity advances)
//   o_tick       : half-period expired this cycle
//   o_lead       : current tick is a leading edge
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_CLK_DIV_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    input  logic             i_shift,
    output logic             o_tick,
    output logic             o_lead
);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_par;

    // Divider capture, half-period down-count and edge parity tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div <= {DIV_W{1'b0}};
            r_cnt <= {DIV_W{1'b0}};
            r_par <= 1'b0;
        end else if (i_load) begin
            r_div <= i_div;
            r_cnt <= i_div;
            r_par <= 1'b0;
        end else if (i_en) begin
            if (r_cnt == {DIV_W{1'b0}}) begin
                r_cnt <= r_div;
                // Parity only advances on real SCLK edges, so the first
                // SHIFT tick is always seen as leading.
                if (i_shift) begin
                    r_par <= ~r_par;
                end else begin
                    r_par <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end else begin
            r_cnt <= r_div;
            r_par <= 1'b0;
        end
    end

    assign o_tick = i_en & (r_cnt == {DIV_W{1'b0}});
    assign o_lead = ~r_par;

endmodule

// File: rtl/spi_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// spi_transfer_ctrl
// Byte-oriented SPI master transfer engine. On an accepted start it drops
// ss_n, waits one half-period (SETUP), produces 2*DATA_W SCLK edges (SHIFT)
// shifting tx MSB-first on mosi and capturing miso, waits one more
// half-period (HOLD), then raises ss_n and pulses done with rx_data updated.
// The edge that ends each half-period is when sclk toggles, so the final
// edge coincides with entry into HOLD.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : start, tx_data, clk_div, cpol, cpha, miso in;
//                  busy, done, rx_data, sclk, mosi, ss_n out (all registered)
// Build option:
//   SPI_MODE_CFG_EN defined   : cpol/cpha latched at start, all four modes.
//   SPI_MODE_CFG_EN undefined : cpol/cpha ignored, fixed mode 0.
// -----------------------------------------------------------------------------
module spi_transfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic                i_clk,
    input  logic                i_rst,
    spi_transfer_ctrl_if.slave  bus
);

    localparam int                EDGE_W    = spi_edge_cnt_w(DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_ctrl_state_t   r_state;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [EDGE_W-1:0] r_edge;
    logic              r_sclk;
    logic              r_mosi;
    logic              r_ss_n;
    logic              r_busy;
    logic              r_done;

    logic w_load;
    logic w_run;
    logic w_shift;
    logic w_tick;
    logic w_lead;
    logic w_cpol_in;
    logic w_cpha_in;
    logic w_cpha;

`ifdef SPI_MODE_CFG_EN
    logic r_cpha;

    assign w_cpol_in = bus.cpol;
    assign w_cpha_in = bus.cpha;
    assign w_cpha    = r_cpha;
`else
    logic w_unused_cfg;

    assign w_cpol_in    = 1'b0;
    assign w_cpha_in    = 1'b0;
    assign w_cpha       = 1'b0;
    assign w_unused_cfg = bus.cpol ^ bus.cpha;
`endif

    assign w_load  = (r_state == IDLE) & bus.start;
    assign w_run   = (r_state != IDLE);
    assign w_shift = (r_state == SHIFT);

    spi_clk_gen #(
        .DIV_W (SPI_CLK_DIV_W)
    ) u_clk_gen (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_div   (bus.clk_div),
        .i_en    (w_run),
        .i_shift (w_shift),
        .o_tick  (w_tick),
        .o_lead  (w_lead)
    );

    // Transfer FSM with shift registers, edge counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_tx      <= {DATA_W{1'b0}};
            r_rx      <= {DATA_W{1'b0}};
            r_rx_data <= {DATA_W{1'b0}};
            r_edge    <= {EDGE_W{1'b0}};
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_ss_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SPI_MODE_CFG_EN
            r_cpha    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_mosi <= 1'b0;
                    if (bus.start) begin
                        r_state <= SETUP;
                        r_busy  <= 1'b1;
                        r_ss_n  <= 1'b0;
                        r_edge  <= {EDGE_W{1'b0}};
                        r_rx    <= {DATA_W{1'b0}};
                        // sclk itself carries the latched idle polarity.
                        r_sclk  <= w_cpol_in;
`ifdef SPI_MODE_CFG_EN
                        r_cpha  <= bus.cpha;
`endif
                        if (w_cpha_in) begin
                            // MSB is launched by edge 1.
                            r_tx <= bus.tx_data;
                        end else begin
                            // MSB must already be on the wire for edge 1.
                            r_tx   <= {bus.tx_data[DATA_W-2:0], 1'b0};
                            r_mosi <= bus.tx_data[DATA_W-1];
                        end
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + EDGE_W'(1);
                        // Launch on trailing edges in mode cpha=0 and on
                        // leading edges in cpha=1; sample on the others.
                        if (w_lead == w_cpha) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                        end else begin
                            r_rx <= {r_rx[DATA_W-2:0], bus.miso};
                        end
                        if (r_edge == LAST_EDGE) begin
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_ss_n    <= 1'b1;
                        r_mosi    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ss_n  <= 1'b1;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.mosi    = r_mosi;
    assign bus.ss_n    = r_ss_n;

endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_transfer_ctrl
// Self-checking bench for spi_transfer_ctrl. Each transfer is observed at the
// pins and compared with what an SPI slave should see: busy/ss_n length of
// 18*H cycles, 16 SCLK edges spaced H apart, the last edge H before ss_n
// rises, the tx byte MSB-first on mosi and the slave's miso byte in rx_data.
// -----------------------------------------------------------------------------
module tb_spi_transfer_ctrl;
    import spi_pkg::*;

    localparam int DW = SPI_DATA_W;
`ifdef SPI_MODE_CFG_EN
    localparam bit CFG_EN = 1'b1;
`else
    localparam bit CFG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    spi_transfer_ctrl_if #(.DATA_W(DW)) bus ();

    spi_transfer_ctrl #(.DATA_W(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic begin_xfer(input logic [DW-1:0] tx, input int div, input logic cpol, input logic cpha);
        bus.tx_data = tx;
        bus.clk_div = 8'(div);
        bus.cpol    = cpol;
        bus.cpha    = cpha;
        bus.start   = 1'b1;
    endtask

    // Observe one accepted transfer at the pins (call at the negedge where
    // start was raised). Acts as the slave on miso: either loops mosi back
    // or presents byte m MSB-first. Optional start glitch at cycle
    // glitch_cyc, optional reset after visible SCLK edge rst_edge.
    task automatic watch_xfer(input string nm, input logic [DW-1:0] tx, input int div,
                              input logic cpol, input logic cpha, input logic loop,
                              input logic [DW-1:0] m, input int glitch_cyc, input int rst_edge);
        int h, edges, busy_n, ssl_n, last_edge_cyc, sp_min, sp_max, samples, done_cyc, idx;
        int dn, ssh;
        logic prev_sclk, prev_mosi, pol, pha, stop, got_done, rst_hit;
        logic [DW-1:0] mseq, exp_rx;
        h = div + 1;
        pol = CFG_EN ? cpol : 1'b0;
        pha = CFG_EN ? cpha : 1'b0;
        exp_rx = loop ? tx : m;
        edges = 0; busy_n = 0; ssl_n = 0; last_edge_cyc = 0; samples = 0; done_cyc = 0;
        sp_min = 1 << 30; sp_max = 0;
        prev_sclk = pol; prev_mosi = 1'b0; mseq = '0;
        stop = 1'b0; got_done = 1'b0; rst_hit = 1'b0;
        for (int cyc = 1; cyc <= 20 * h + 8 && !stop; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == glitch_cyc) begin
                bus.start   = 1'b1;
                bus.tx_data = '1;
                bus.clk_div = 8'd7;
                bus.cpol    = ~cpol;
                bus.cpha    = ~cpha;
            end
            if (cyc == 1) begin
                check_eq({nm, "/ss_n_low"}, 32'(bus.ss_n), 32'd0);
                check_eq({nm, "/busy_set"}, 32'(bus.busy), 32'd1);
                check_eq({nm, "/sclk_idle"}, 32'(bus.sclk), 32'(pol));
            end
            if (bus.sclk !== prev_sclk) begin
                edges++;
                if (edges > 1) begin
                    if (cyc - last_edge_cyc < sp_min) sp_min = cyc - last_edge_cyc;
                    if (cyc - last_edge_cyc > sp_max) sp_max = cyc - last_edge_cyc;
                end
                last_edge_cyc = cyc;
                // Slave samples on odd edges for cpha=0, even edges for cpha=1.
                if ((edges % 2 == 1) != pha) begin
                    mseq = {mseq[DW-2:0], prev_mosi};
                    samples++;
                end
            end
            prev_sclk = bus.sclk;
            prev_mosi = bus.mosi;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.ss_n === 1'b0) ssl_n++;
            if (bus.done === 1'b1) begin
                got_done = 1'b1;
                done_cyc = cyc;
                stop     = 1'b1;
            end else if (rst_edge > 0 && edges == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_eq({nm, "/rst_ss_n"}, 32'(bus.ss_n), 32'd1);
                check_eq({nm, "/rst_sclk"}, 32'(bus.sclk), 32'd0);
                check_eq({nm, "/rst_mosi"}, 32'(bus.mosi), 32'd0);
                check_eq({nm, "/rst_busy"}, 32'(bus.busy), 32'd0);
                check_eq({nm, "/rst_done"}, 32'(bus.done), 32'd0);
                check_eq({nm, "/rst_rx"}, 32'(bus.rx_data), 32'd0);
                dn = 0; ssh = 0;
                for (int j = 0; j < 4 * h + 8; j++) begin
                    @(negedge clk);
                    if (bus.done === 1'b1) dn++;
                    if (bus.ss_n !== 1'b1) ssh++;
                end
                check_eq({nm, "/rst_no_done"}, 32'(dn), 32'd0);
                check_eq({nm, "/rst_ss_idle"}, 32'(ssh), 32'd0);
                rst_hit = 1'b1;
                stop    = 1'b1;
            end else begin
                idx = edges / 2;
                if (loop) bus.miso = bus.mosi;
                else if (idx < DW) bus.miso = m[DW-1-idx];
                else bus.miso = 1'b0;
            end
        end
        if (rst_edge > 0) begin
            check_eq({nm, "/rst_reached"}, 32'(rst_hit), 32'd1);
        end else begin
            check_eq({nm, "/done_seen"}, 32'(got_done), 32'd1);
            if (got_done) begin
                check_eq({nm, "/busy_len"}, 32'(busy_n), 32'(18 * h));
                check_eq({nm, "/ss_low_len"}, 32'(ssl_n), 32'(18 * h));
                check_eq({nm, "/edges"}, 32'(edges), 32'd16);
                check_eq({nm, "/half_min"}, 32'(sp_min), 32'(h));
                check_eq({nm, "/half_max"}, 32'(sp_max), 32'(h));
                check_eq({nm, "/last_edge_gap"}, 32'(done_cyc - last_edge_cyc), 32'(h));
                check_eq({nm, "/mosi_bits"}, 32'(samples), 32'(DW));
                check_eq({nm, "/mosi_seq"}, 32'(mseq), 32'(tx));
                check_eq({nm, "/rx_data"}, 32'(bus.rx_data), 32'(exp_rx));
                check_eq({nm, "/done_busy"}, 32'(bus.busy), 32'd0);
                check_eq({nm, "/done_ss_n"}, 32'(bus.ss_n), 32'd1);
                check_eq({nm, "/done_sclk"}, 32'(bus.sclk), 32'(pol));
                check_eq({nm, "/done_mosi"}, 32'(bus.mosi), 32'd0);
            end
        end
    endtask

    initial begin
        logic [DW-1:0] r_tx_v, r_m_v;
        int            r_div_v;
        logic          r_pol_v, r_pha_v, r_loop_v;

        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = '0;
        bus.clk_div = 8'd0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        bus.miso    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset/busy", 32'(bus.busy), 32'd0);
        check_eq("reset/done", 32'(bus.done), 32'd0);
        check_eq("reset/rx_data", 32'(bus.rx_data), 32'd0);
        check_eq("reset/sclk", 32'(bus.sclk), 32'd0);
        check_eq("reset/mosi", 32'(bus.mosi), 32'd0);
        check_eq("reset/ss_n", 32'(bus.ss_n), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0, fastest SCLK, loopback.
        begin_xfer(8'hA5, 0, 1'b0, 1'b0);
        watch_xfer("t1_mode0", 8'hA5, 0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
        @(negedge clk);
        check_eq("t1_mode0/single_done", 32'(bus.done), 32'd0);

        // Divider 3, miso tied high, then back-to-back start in the done cycle.
        begin_xfer(8'h3C, 3, 1'b0, 1'b0);
        watch_xfer("t2_div3", 8'h3C, 3, 1'b0, 1'b0, 1'b0, 8'hFF, 0, 0);
        begin_xfer(8'h0F, 0, 1'b0, 1'b0);
        watch_xfer("t3_b2b", 8'h0F, 0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
        @(negedge clk);
        check_eq("t3_b2b/single_done", 32'(bus.done), 32'd0);

        // Start and config changes mid-transfer must be ignored.
        begin_xfer(8'h5A, 2, 1'b0, 1'b0);
        watch_xfer("t4_glitch", 8'h5A, 2, 1'b0, 1'b0, 1'b1, 8'h00, 10, 0);
        @(negedge clk);
        check_eq("t4_glitch/single_done", 32'(bus.done), 32'd0);
        check_eq("t4_glitch/no_restart", 32'(bus.busy), 32'd0);

        // Reset at SHIFT edge 5, then a normal transfer.
        begin_xfer(8'hC3, 1, 1'b0, 1'b0);
        watch_xfer("t5_rst", 8'hC3, 1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 5);
        begin_xfer(8'h96, 0, 1'b0, 1'b0);
        watch_xfer("t5_after", 8'h96, 0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 0);
        @(negedge clk);

        // cpol=1, cpha=1 request (honoured only with mode configuration built in).
        begin_xfer(8'h81, 1, 1'b1, 1'b1);
        watch_xfer("t6_mode3", 8'h81, 1, 1'b1, 1'b1, 1'b1, 8'h00, 0, 0);
        @(negedge clk);
        check_eq("t6_mode3/sclk_rest", 32'(bus.sclk), 32'(CFG_EN ? 1'b1 : 1'b0));

        // Randomised transfers.
        for (int r = 0; r < 8; r++) begin
            r_tx_v   = DW'($urandom);
            r_m_v    = DW'($urandom);
            r_div_v  = int'($urandom_range(0, 4));
            r_pol_v  = 1'($urandom_range(0, 1));
            r_pha_v  = 1'($urandom_range(0, 1));
            r_loop_v = 1'($urandom_range(0, 1));
            begin_xfer(r_tx_v, r_div_v, r_pol_v, r_pha_v);
            watch_xfer($sformatf("rnd%0d", r), r_tx_v, r_div_v, r_pol_v, r_pha_v,
                       r_loop_v, r_m_v, 0, 0);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
